// File: rtl/uart_rx_buffer_ctrl.sv
// uart_rx_buffer_ctrl: receive-side buffer between the UART receiver and the CPU bus.
// Bytes go into a first-word-fall-through FIFO. The block also keeps a sticky
// overflow flag and an idle-line timeout. It raises a level irq on the fill
// threshold or on that timeout.
module uart_rx_buffer_ctrl #(
  parameter int DEPTH_LOG2    = 4,
  parameter int IRQ_THRESHOLD = 8,
  parameter int TIMEOUT_CLKS  = 4340
) (
  input  logic                  i_Clock,
  input  logic                  reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic                  timeout,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] IRQ_THR_C = CW'(IRQ_THRESHOLD);
  localparam logic [TW-1:0] T_LAST_C  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_COUNT   = 2'd1,
    T_EXPIRED = 2'd2
  } tstate_e;

  // Storage is never reset; only pointers and flags are.
  logic [7:0]            mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_q, timeout_d;
  logic                  irq_q, irq_d;
  logic [7:0]            rd_data_q, rd_data_d;
  tstate_e               state_q, state_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;

  logic push_s;
  logic pop_s;
  logic drop_s;

  // A pop always makes room, so a push into a full FIFO is legal when rd_en is set.
  always_comb begin
    pop_s  = rd_en && !empty_q;
    push_s = i_Rx_DV && (!full_q || rd_en);
    drop_s = i_Rx_DV && full_q && !rd_en;
  end

  // Next values for pointers, occupancy and the FWFT head register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == DEPTH_C);
    // The new head bypasses storage when it is the byte being written this cycle.
    if (count_d == CW'(0)) begin
      rd_data_d = 8'h00;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = i_Rx_Byte;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Idle-timeout FSM: next state, idle counter and timeout flag.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      T_IDLE: begin
        tcnt_d    = TW'(0);
        timeout_d = 1'b0;
        if (count_d != CW'(0)) begin
          state_d = T_COUNT;
        end else begin
          state_d = T_IDLE;
        end
      end
      T_COUNT: begin
        timeout_d = 1'b0;
        if (count_d == CW'(0)) begin
          state_d = T_IDLE;
          tcnt_d  = TW'(0);
        end else if (push_s || pop_s) begin
          tcnt_d = TW'(0);
        end else if (tcnt_q == T_LAST_C) begin
          state_d   = T_EXPIRED;
          tcnt_d    = TW'(0);
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      T_EXPIRED: begin
        tcnt_d = TW'(0);
        if (pop_s) begin
          timeout_d = 1'b0;
          if (count_d == CW'(0)) begin
            state_d = T_IDLE;
          end else begin
            state_d = T_COUNT;
          end
        end else begin
          timeout_d = 1'b1;
          state_d   = T_EXPIRED;
        end
      end
      default: begin
        state_d   = T_IDLE;
        tcnt_d    = TW'(0);
        timeout_d = 1'b0;
      end
    endcase
    irq_d = (count_d >= IRQ_THR_C) || timeout_d;
  end

  // Write accepted bytes into storage (storage has no reset).
  always_ff @(posedge i_Clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_Rx_Byte;
    end
  end

  // Control and flag registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      irq_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      state_q    <= T_IDLE;
      tcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Scoreboard bench for uart_rx_buffer_ctrl. Stimulus pushes expected bytes into
// a queue. A negedge monitor pops the queue and compares on each CPU pop.
module tb_uart_rx_buffer_ctrl;

  localparam int DL2 = 4;
  localparam int THR = 8;
  localparam int TCK = 4340;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [7:0]  rd_data;
  logic [DL2:0] count;
  logic        empty, full, overflow, timeout, irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  uart_rx_buffer_ctrl #(.DEPTH_LOG2(DL2), .IRQ_THRESHOLD(THR), .TIMEOUT_CLKS(TCK)) dut (
    .i_Clock(clk), .reset(reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .rd_en(rd_en), .rd_data(rd_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .clr_ovf(clr_ovf), .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each pop the DUT is about to perform must present the scoreboard head.
  always @(negedge clk) begin
    if (!reset && rd_en) begin
      if (exp_q.size() > 0) begin
        chk("pop_data", rd_data, exp_q.pop_front());
      end else begin
        chk("pop_on_empty_flag", empty, 1);
      end
    end
  end

  // One cycle of stimulus; accepted bytes enter the scoreboard after the edge.
  task automatic op(input logic dv, input logic [7:0] b, input logic rd, input logic clr);
    logic acc;
    i_Rx_DV = dv; i_Rx_Byte = b; rd_en = rd; clr_ovf = clr;
    acc = dv && ((exp_q.size() < 16) || rd);
    @(posedge clk);
    if (acc) exp_q.push_back(b);
    #1;
    i_Rx_DV = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    chk_reset_vals("reset");

    // Basic three-byte burst.
    op(1, 8'h41, 0, 0); op(1, 8'h42, 0, 0); op(1, 8'h43, 0, 0);
    chk("t1_count", count, 3);
    chk("t1_head", rd_data, 8'h41);
    for (int i = 0; i < 3; i++) op(0, 8'h00, 1, 0);
    chk("t1_empty", empty, 1);
    chk("t1_rd_data_empty", rd_data, 8'h00);

    // Fill, overflow, drain, clear.
    do_reset();
    for (int i = 0; i < 16; i++) op(1, 8'(i), 0, 0);
    chk("t2_full16", full, 1);
    chk("t2_ovf16", overflow, 0);
    op(1, 8'h10, 0, 0);
    chk("t2_ovf17", overflow, 1);
    chk("t2_count17", count, 16);
    for (int i = 0; i < 16; i++) op(0, 8'h00, 1, 0);
    chk("t2_empty", empty, 1);
    chk("t2_ovf_sticky", overflow, 1);
    op(0, 8'h00, 0, 1);
    chk("t2_ovf_clr", overflow, 0);

    // Push+pop while full, then push+pop while empty.
    do_reset();
    for (int i = 0; i < 16; i++) op(1, 8'hB0 + 8'(i), 0, 0);
    op(1, 8'hAA, 1, 0);
    chk("t3_ovf", overflow, 0);
    chk("t3_count", count, 16);
    chk("t3_full", full, 1);
    for (int i = 0; i < 16; i++) op(0, 8'h00, 1, 0);
    chk("t3_drained", empty, 1);
    op(1, 8'h55, 1, 0);
    chk("t3_empty_pp_count", count, 1);
    chk("t3_empty_pp_data", rd_data, 8'h55);
    op(0, 8'h00, 1, 0);

    // Fill-threshold interrupt.
    do_reset();
    for (int i = 0; i < 7; i++) op(1, 8'hC0 + 8'(i), 0, 0);
    chk("t4_irq7", irq, 0);
    op(1, 8'hC7, 0, 0);
    chk("t4_irq8", irq, 1);
    op(0, 8'h00, 1, 0);
    chk("t4_irq_pop", irq, 0);
    for (int i = 0; i < 7; i++) op(0, 8'h00, 1, 0);

    // Idle timeout on a single byte.
    do_reset();
    op(1, 8'h11, 0, 0);
    repeat (TCK - 1) @(posedge clk);
    #1;
    chk("t5_timeout_early", timeout, 0);
    @(posedge clk); #1;
    chk("t5_timeout", timeout, 1);
    chk("t5_irq", irq, 1);
    op(0, 8'h00, 1, 0);
    chk("t5_timeout_clr", timeout, 0);
    chk("t5_irq_clr", irq, 0);
    chk("t5_empty", empty, 1);
    repeat (TCK + 4) @(posedge clk);
    #1;
    chk("t5_idle_no_timeout", timeout, 0);

    // A push at cycle 4000 restarts the idle count.
    op(1, 8'h22, 0, 0);
    repeat (3999) @(posedge clk);
    #1;
    op(1, 8'h23, 0, 0);
    repeat (TCK - 1) @(posedge clk);
    #1;
    chk("t5b_timeout_early", timeout, 0);
    @(posedge clk); #1;
    chk("t5b_timeout", timeout, 1);
    op(1, 8'h24, 0, 0);
    chk("t5b_push_keeps", timeout, 1);
    op(0, 8'h00, 1, 0);
    chk("t5b_pop_clears", timeout, 0);
    chk("t5b_irq_clr", irq, 0);
    chk("t5b_count", count, 2);
    op(0, 8'h00, 1, 0);
    op(0, 8'h00, 1, 0);
    chk("t5b_empty", empty, 1);

    // Reset in mid-stream.
    do_reset();
    for (int i = 0; i < 20; i++) op(1, 8'h60 + 8'(i), 0, 0);
    for (int i = 0; i < 4; i++) op(0, 8'h00, 1, 0);
    chk("t6_count12", count, 12);
    chk("t6_ovf", overflow, 1);
    do_reset();
    chk_reset_vals("t6_reset");
    op(1, 8'h7E, 0, 0);
    chk("t6_data", rd_data, 8'h7E);
    chk("t6_count1", count, 1);
    op(0, 8'h00, 1, 0);
    chk("t6_end_empty", empty, 1);
    chk("t6_scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
